id_ex_stage: RTL
================

# id_ex_stage

Pipeline stage between instruction decode and execute, directly downstream of the register file. Captures decoded operands (register-file read data, immediate, control) into the ID/EX register, detects load-use hazards and issues a one-cycle stall with bubble insertion, honours branch/jump flush, and presents forwarded ALU operands to EX from the EX/MEM and MEM/WB stages. Also keeps a saturating count of stall cycles for performance debug.

## Interface
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle passed through unchanged
- CNT_W, 16, width of stall counter

- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  5 each  source register numbers (as driven to register file read ports)
- id_dest  in  5  destination register number
- id_rdata1, id_rdata2  in  32 each  register file read data for rs/rt (write-through already applied)
- id_imm  in  32  extended immediate
- id_ctrl  in  CTRL_W  pass-through control bundle
- id_RegWrite, id_MemRead  in  1 each  decoded write-back and load flags
- flush  in  1  kill instruction currently in ID (branch/jump taken)
- exmem_RegWrite  in  1; exmem_dest  in  5; exmem_result  in  32  EX/MEM producer
- memwb_RegWrite  in  1; memwb_dest  in  5; memwb_result  in  32  MEM/WB producer
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_rs, ex_rt, ex_dest  out  5 each
- ex_imm  out  32; ex_ctrl  out  CTRL_W; ex_RegWrite, ex_MemRead  out  1 each
- ex_op_a, ex_op_b  out  32 each  forwarded operands (combinational)
- stall_count  out  CNT_W  saturating stall-cycle count

## Operation
- Internal registers: ex_valid, ex_rs, ex_rt, ex_dest, ex_imm, ex_ctrl, ex_RegWrite, ex_MemRead, ex_rdata1, ex_rdata2, stall_count.
- Hazard: stall = id_valid & ex_valid & ex_MemRead & (ex_dest != 0) & (ex_dest == id_rs | ex_dest == id_rt) & ~flush.
- Per-edge update priority: reset > flush > stall > capture.
  - reset: all registers 0 (ex_valid=0, stall_count=0).
  - flush or stall: load bubble: ex_valid, ex_RegWrite, ex_MemRead, ex_ctrl forced 0; other fields don't-care (implemented as 0).
  - capture: copy all id_* into ex_*; ex_valid<=id_valid; if id_valid=0, RegWrite/MemRead/ctrl loaded as 0.
- Forwarding for op_a (op_b identical with ex_rt/ex_rdata2):
  - ex_rs == 0 -> 0.
  - else exmem_RegWrite & exmem_dest == ex_rs -> exmem_result.
  - else memwb_RegWrite & memwb_dest == ex_rs -> memwb_result.
  - else ex_rdata1.
  - EX/MEM beats MEM/WB when both match (younger producer wins).
- Producer three ahead is covered by register-file write-through; not forwarded here.
- stall_count: +1 on each edge where stall=1 and reset=0; holds at all-ones.

## Timing
- Capture latency 1 cycle: id_* sampled at edge N appear on ex_* after edge N.
- stall, ex_op_a, ex_op_b are combinational; no added latency.
- Load-use costs exactly 1 bubble: after stall edge, load is in MEM/WB while consumer enters EX and takes memwb_result.
- Stall never lasts >1 consecutive cycle for the same ID instruction (after bubble, ex_valid=0 deasserts stall).
- flush with stall active: stall output 0, bubble inserted, stall_count unchanged.
- reset asserted mid-stall: next edge all outputs 0; stall deasserts combinationally (ex_valid=0).

## Test plan
- Reset: hold reset 2 cycles with id_valid=1 -> ex_valid=0, ex_op_a=ex_op_b=0, stall_count=0, stall=0.
- Capture: id_rs=3, id_rdata1=0x11, id_rt=4, id_rdata2=0x22, no producers -> next cycle ex_op_a=0x11, ex_op_b=0x22, ex_valid=1.
- Load-use: EX holds lw dest=8 (MemRead=1), ID add rs=8 -> stall=1, next cycle ex_valid=0, stall_count=1; following edge add captured, memwb_dest=8, memwb_result=0xDEAD -> ex_op_a=0xDEAD.
- Forward priority: ex_rs=5, exmem_dest=5 result 0xAAAA, memwb_dest=5 result 0xBBBB, both RegWrite -> ex_op_a=0xAAAA; exmem_RegWrite=0 -> 0xBBBB.
- Zero register: ex_rs=0, exmem_dest=0, exmem_RegWrite=1, result 0x1234 -> ex_op_a=0.
- Flush vs stall: load-use condition plus flush=1 -> stall=0, ex_valid=0 next cycle, stall_count unchanged; force 0xFFFF stalls -> count stays 0xFFFF.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Bundle of decode-side inputs, EX/MEM and MEM/WB producer taps, and ID/EX outputs.
// The stage itself connects through the slave modport; the driving environment uses the master modport.
interface id_ex_stage_if #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_dest;
    logic [31:0]       id_rdata1;
    logic [31:0]       id_rdata2;
    logic [31:0]       id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_RegWrite;
    logic              id_MemRead;
    logic              flush;

    logic              exmem_RegWrite;
    logic [4:0]        exmem_dest;
    logic [31:0]       exmem_result;
    logic              memwb_RegWrite;
    logic [4:0]        memwb_dest;
    logic [31:0]       memwb_result;

    logic              stall;
    logic              ex_valid;
    logic [4:0]        ex_rs;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_dest;
    logic [31:0]       ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_RegWrite;
    logic              ex_MemRead;
    logic [31:0]       ex_op_a;
    logic [31:0]       ex_op_b;
    logic [CNT_W-1:0]  stall_count;

    modport slave (
        input  id_valid, id_rs, id_rt, id_dest, id_rdata1, id_rdata2, id_imm,
               id_ctrl, id_RegWrite, id_MemRead, flush,
               exmem_RegWrite, exmem_dest, exmem_result,
               memwb_RegWrite, memwb_dest, memwb_result,
        output stall, ex_valid, ex_rs, ex_rt, ex_dest, ex_imm, ex_ctrl,
               ex_RegWrite, ex_MemRead, ex_op_a, ex_op_b, stall_count
    );

    modport master (
        output id_valid, id_rs, id_rt, id_dest, id_rdata1, id_rdata2, id_imm,
               id_ctrl, id_RegWrite, id_MemRead, flush,
               exmem_RegWrite, exmem_dest, exmem_result,
               memwb_RegWrite, memwb_dest, memwb_result,
        input  stall, ex_valid, ex_rs, ex_rt, ex_dest, ex_imm, ex_ctrl,
               ex_RegWrite, ex_MemRead, ex_op_a, ex_op_b, stall_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble insertion, flush, operand forwarding
// from EX/MEM and MEM/WB, and a saturating stall-cycle counter.
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input logic          clk,
    input logic          reset,
    id_ex_stage_if.slave bus
);

    logic              ex_valid_q,     ex_valid_d;
    logic [4:0]        ex_rs_q,        ex_rs_d;
    logic [4:0]        ex_rt_q,        ex_rt_d;
    logic [4:0]        ex_dest_q,      ex_dest_d;
    logic [31:0]       ex_imm_q,       ex_imm_d;
    logic [CTRL_W-1:0] ex_ctrl_q,      ex_ctrl_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic              ex_mem_read_q,  ex_mem_read_d;
    logic [31:0]       ex_rdata1_q,    ex_rdata1_d;
    logic [31:0]       ex_rdata2_q,    ex_rdata2_d;
    logic [CNT_W-1:0]  stall_count_q,  stall_count_d;

    logic              stall;
    logic              dest_hits;

    // A load in EX whose destination feeds the ID instruction must wait one cycle;
    // a taken branch kills the ID instruction so there is nothing to wait for.
    always_comb begin
        dest_hits = (ex_dest_q == bus.id_rs) || (ex_dest_q == bus.id_rt);
        stall     = bus.id_valid && ex_valid_q && ex_mem_read_q &&
                    (ex_dest_q != 5'd0) && dest_hits && !bus.flush;
    end

    always_comb begin
        ex_valid_d     = bus.id_valid;
        ex_rs_d        = bus.id_rs;
        ex_rt_d        = bus.id_rt;
        ex_dest_d      = bus.id_dest;
        ex_imm_d       = bus.id_imm;
        ex_rdata1_d    = bus.id_rdata1;
        ex_rdata2_d    = bus.id_rdata2;
        ex_ctrl_d      = bus.id_valid ? bus.id_ctrl : '0;
        ex_reg_write_d = bus.id_valid && bus.id_RegWrite;
        ex_mem_read_d  = bus.id_valid && bus.id_MemRead;
        stall_count_d  = stall_count_q;

        if (bus.flush || stall) begin
            ex_valid_d     = 1'b0;
            ex_rs_d        = 5'd0;
            ex_rt_d        = 5'd0;
            ex_dest_d      = 5'd0;
            ex_imm_d       = 32'd0;
            ex_rdata1_d    = 32'd0;
            ex_rdata2_d    = 32'd0;
            ex_ctrl_d      = '0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
        end

        if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q     <= 1'b0;
            ex_rs_q        <= 5'd0;
            ex_rt_q        <= 5'd0;
            ex_dest_q      <= 5'd0;
            ex_imm_q       <= 32'd0;
            ex_ctrl_q      <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_rdata1_q    <= 32'd0;
            ex_rdata2_q    <= 32'd0;
            stall_count_q  <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dest_q      <= ex_dest_d;
            ex_imm_q       <= ex_imm_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_rdata1_q    <= ex_rdata1_d;
            ex_rdata2_q    <= ex_rdata2_d;
            stall_count_q  <= stall_count_d;
        end
    end

    // Younger producer (EX/MEM) wins over MEM/WB; register 0 is never forwarded.
    function automatic logic [31:0] forward_operand(
        input logic [4:0]  src,
        input logic [31:0] rf_data,
        input logic        exmem_we,
        input logic [4:0]  exmem_dst,
        input logic [31:0] exmem_val,
        input logic        memwb_we,
        input logic [4:0]  memwb_dst,
        input logic [31:0] memwb_val
    );
        logic [31:0] result;
        if (src == 5'd0) begin
            result = 32'd0;
        end else if (exmem_we && (exmem_dst == src)) begin
            result = exmem_val;
        end else if (memwb_we && (memwb_dst == src)) begin
            result = memwb_val;
        end else begin
            result = rf_data;
        end
        return result;
    endfunction

    always_comb begin
        bus.ex_op_a = forward_operand(ex_rs_q, ex_rdata1_q,
                                      bus.exmem_RegWrite, bus.exmem_dest, bus.exmem_result,
                                      bus.memwb_RegWrite, bus.memwb_dest, bus.memwb_result);
        bus.ex_op_b = forward_operand(ex_rt_q, ex_rdata2_q,
                                      bus.exmem_RegWrite, bus.exmem_dest, bus.exmem_result,
                                      bus.memwb_RegWrite, bus.memwb_dest, bus.memwb_result);
    end

    assign bus.stall       = stall;
    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_rs       = ex_rs_q;
    assign bus.ex_rt       = ex_rt_q;
    assign bus.ex_dest     = ex_dest_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_ctrl     = ex_ctrl_q;
    assign bus.ex_RegWrite = ex_reg_write_q;
    assign bus.ex_MemRead  = ex_mem_read_q;
    assign bus.stall_count = stall_count_q;

endmodule
